// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default geometry for the fetch front end
package fetch_pkg;
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2} state_t;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INSTR_W = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, req/ack instruction fetch and valid/ready hand-off to decode with redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC[ADDR_W-1:0]
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        fetch_count
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_n, pend_pc, pend_pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic instr_valid_n, flush_pending, flush_pending_n;
  logic [31:0] fetch_count_n;
  assign imem_req = state == S_FETCH;
  assign imem_addr = pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_BOOT;
      pc <= RESET_PC;
      instr <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
      flush_pending <= 1'b0;
      pend_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      instr <= instr_n;
      instr_valid <= instr_valid_n;
      fetch_count <= fetch_count_n;
      flush_pending <= flush_pending_n;
      pend_pc <= pend_pc_n;
    end
  // pc only moves on an ack or out of S_HOLD, keeping imem_addr stable while a request is open
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = instr;
    instr_valid_n = instr_valid;
    fetch_count_n = fetch_count;
    flush_pending_n = flush_pending;
    pend_pc_n = pend_pc;
    case (state)
      S_BOOT: begin
        state_n = S_FETCH;
        pc_n = flush ? flush_pc : pc;
      end
      S_FETCH:
        if (!imem_ack) begin
          flush_pending_n = flush | flush_pending;
          pend_pc_n = flush ? flush_pc : pend_pc;
        end else if (flush | flush_pending) begin
          pc_n = flush ? flush_pc : pend_pc;
          flush_pending_n = 1'b0;
        end else begin
          instr_n = imem_rdata;
          instr_valid_n = 1'b1;
          state_n = S_HOLD;
        end
      S_HOLD:
        if (flush) begin
          pc_n = flush_pc;
          instr_valid_n = 1'b0;
          state_n = S_FETCH;
        end else if (instr_ready) begin
          pc_n = next_pc;
          instr_valid_n = 1'b0;
          fetch_count_n = fetch_count + 32'd1;
          state_n = S_FETCH;
        end
      default: state_n = S_BOOT;
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected decode words checked by a monitor
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pc, next_pc, flush_pc = '0, imem_addr, imem_rdata, instr, fetch_count;
  logic flush = 1'b0, imem_req, imem_ack, instr_valid, instr_ready = 1'b0;
  logic mem_en = 1'b1, man_ack = 1'b0;
  int wait_n = 0, cnt = 0, total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic pv = 1'b0;
  always #5 clk = ~clk;
  assign next_pc = pc + 32'd1;
  assign imem_rdata = 32'hA0A0_0001 + imem_addr;
  assign imem_ack = mem_en ? (imem_req && cnt == wait_n) : man_ack;
  always @(posedge clk) cnt <= (!imem_req || imem_ack) ? 0 : cnt + 1;
  fetch_unit dut (
    .clk(clk), .rst(rst), .pc(pc), .next_pc(next_pc), .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_count(fetch_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (instr_valid && !pv) begin
      if (exp_q.size() == 0) check("unexpected_instr_valid", 32'd1, 32'd0);
      else check("instr_word", instr, exp_q.pop_front());
    end
    pv = instr_valid;
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_count", fetch_count, 32'd0);
    exp_q.push_back(32'hA0A0_0001);
    rst = 1'b0;
    @(negedge clk);
    check("boot_req", {31'd0, imem_req}, 32'd1);
    check("boot_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("first_valid", {31'd0, instr_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr, 32'hA0A0_0001);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_pc", pc, 32'h0);
    end
    for (int k = 1; k <= 3; k++) exp_q.push_back(32'hA0A0_0001 + k);
    instr_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("seq_req", {31'd0, imem_req}, 32'd1);
      check("seq_addr", imem_addr, k);
      check("seq_count", fetch_count, k);
      if (k == 3) instr_ready = 1'b0;
      @(negedge clk);
      check("seq_valid", {31'd0, instr_valid}, 32'd1);
    end
    exp_q.push_back(32'hA0A0_0005);
    wait_n = 3;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("ws_count", fetch_count, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("ws_req", {31'd0, imem_req}, 32'd1);
      check("ws_addr", imem_addr, 32'd4);
      check("ws_valid", {31'd0, instr_valid}, 32'd0);
    end
    @(negedge clk);
    check("ws_valid_out", {31'd0, instr_valid}, 32'd1);
    flush = 1'b1;
    flush_pc = 32'h10;
    instr_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    instr_ready = 1'b0;
    check("fr_pc", pc, 32'h10);
    check("fr_count", fetch_count, 32'd4);
    check("fr_valid", {31'd0, instr_valid}, 32'd0);
    check("fr_addr", imem_addr, 32'h10);
    @(negedge clk);
    flush = 1'b1;
    flush_pc = 32'h40;
    check("pend_addr_c2", imem_addr, 32'h10);
    @(negedge clk);
    flush = 1'b0;
    check("pend_addr_c3", imem_addr, 32'h10);
    @(negedge clk);
    check("pend_addr_ack", imem_addr, 32'h10);
    check("pend_req_ack", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_drop", {31'd0, instr_valid}, 32'd0);
    flush = 1'b1;
    flush_pc = 32'h60;
    @(negedge clk);
    flush_pc = 32'h80;
    @(negedge clk);
    flush = 1'b0;
    check("pend2_addr", imem_addr, 32'h40);
    @(negedge clk);
    check("pend2_addr_ack", imem_addr, 32'h40);
    exp_q.push_back(32'hA0A0_0081);
    @(negedge clk);
    check("latest_wins_addr", imem_addr, 32'h80);
    check("latest_wins_drop", {31'd0, instr_valid}, 32'd0);
    wait_n = 0;
    @(negedge clk);
    check("latest_valid", {31'd0, instr_valid}, 32'd1);
    wait_n = 3;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("pre_rst_count", fetch_count, 32'd5);
    check("pre_rst_addr", imem_addr, 32'h81);
    mem_en = 1'b0;
    man_ack = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_count", fetch_count, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_instr", instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    man_ack = 1'b0;
    check("late_ack_req", {31'd0, imem_req}, 32'd1);
    check("late_ack_addr", imem_addr, 32'h0);
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check("late_ack_still_idle", {31'd0, instr_valid}, 32'd0);
    check("late_ack_pc", pc, 32'h0);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
